reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V datapath; next generation of the single-write, dual-read reg_file.
- Adds:
  - a configurable number of read ports,
  - two write ports with fixed priority,
  - optional write-to-read bypass,
  - hardwired-zero register x0,
  - a per-register busy scoreboard (reserve at issue, release at writeback) so the pipeline can detect RAW hazards.
- Sits between decode/issue (read and reserve) and writeback (write and release).

Parameters:
- ADDR_SIZE, 5, register address width; depth = 2^ADDR_SIZE.
- WORD_SIZE, 64, register data width.
- NUM_RD, 3, number of read ports (1..8).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en0  in  1  write port 0 enable.
- wr_add0  in  ADDR_SIZE  write port 0 address.
- wr_data0  in  WORD_SIZE  write port 0 data.
- wr_en1  in  1  write port 1 enable (priority over port 0).
- wr_add1  in  ADDR_SIZE  write port 1 address.
- wr_data1  in  WORD_SIZE  write port 1 data.
- rd_add  in  NUM_RD*ADDR_SIZE  read addresses, port k at bits [k*ADDR_SIZE +: ADDR_SIZE].
- rd_data  out  NUM_RD*WORD_SIZE  read data, port k at [k*WORD_SIZE +: WORD_SIZE].
- rd_busy  out  NUM_RD  busy flag of each read port's register.
- rsv_en  in  1  reserve request (destination allocated at issue).
- rsv_add  in  ADDR_SIZE  register to reserve.
- busy_vec  out  2^ADDR_SIZE  registered busy bit of every register.

Behaviour:
- Reset:
  - When rst=1 at a rising edge, all registers are cleared to 0 and all busy bits are cleared.
  - Writes and reserves in that cycle are ignored.
  - After that edge: rd_data=0 for all ports, rd_busy=0, busy_vec=0.
- Reads:
  - Combinational, 0-cycle latency from rd_add.
  - Address 0 always returns 0 and rd_busy=0.
- Writes:
  - A register updates at the rising edge when its wr_en is high and its address is nonzero.
  - Writes to address 0 are dropped.
  - Both ports to the same address in the same cycle: port 1 data is stored.
- Bypass (BYPASS=1):
  - If a read address is nonzero and matches an enabled write address in the same cycle, rd_data returns that write data. Port 1 wins over port 0.
  - rst=1 suppresses bypass, so rd_data reads the stored value.
- BYPASS=0: new data is visible from the cycle after the write edge.
- Scoreboard:
  - Busy bit set: at the edge where rsv_en=1 and rsv_add!=0.
  - Busy bit cleared: at the edge where any enabled write targets that address.
  - Reserve and write to the same address in the same cycle: busy ends up set, because the reservation belongs to a newer producer. The write data is still stored.
  - Reserve of an already-busy register: the bit stays set; there is no counting.
  - Busy bit 0 is constant 0.
- rd_busy[k]:
  - = busy_vec[addr_k], except when BYPASS=1 and a same-cycle enabled write targets addr_k with no same-cycle reserve of addr_k; then it is 0.
- Reset mid-operation: pending busy bits are discarded. The pipeline is flushed by the same reset.
- No X propagation: undefined addresses do not exist because depth is a full power of two.

Test Plan:
- Reset then basic write/read:
  - rst=1 one cycle; then wr_en0=1, wr_add0=1, wr_data0=464.
  - Next cycle, rd_add port0=1 reads 464; ports 1/2 at address 2 read 0.
- Dual-write collision:
  - wr_add0=wr_add1=17, wr_data0=433, wr_data1=900.
  - After the edge, reading 17 returns 900.
  - Separate addresses 3/4 with 11/22 both stored.
- x0:
  - Write 0x1234 to address 0 and reserve address 0.
  - Reading address 0 returns 0, rd_busy=0, busy_vec[0]=0.
- Bypass:
  - BYPASS=1: with wr_en1=1, wr_add1=5, wr_data1=77, read address 5 in the same cycle returns 77.
  - BYPASS=0 build: same stimulus returns the old value 0, and 77 the next cycle.
- Scoreboard:
  - rsv_add=9 sets busy_vec[9]=1 and rd_busy=1 for a reader of 9.
  - A write to 9 clears it after the edge; with bypass, rd_busy=0 in the write cycle.
  - Simultaneous reserve and write of 9 leaves busy=1 and data updated.
- Reset mid-operation:
  - Registers 1 and 17 written, 9 and 10 reserved; assert rst with a concurrent write to 2.
  - Next cycle all reads are 0, busy_vec=0, and register 2 stays 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, two prioritised
// writes, optional write-to-read bypass, hardwired x0 and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 64,
  parameter int NUM_RD    = 3,
  parameter int BYPASS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en0,
  input  logic [ADDR_SIZE-1:0]        wr_add0,
  input  logic [WORD_SIZE-1:0]        wr_data0,
  input  logic                        wr_en1,
  input  logic [ADDR_SIZE-1:0]        wr_add1,
  input  logic [WORD_SIZE-1:0]        wr_data1,
  input  logic [NUM_RD*ADDR_SIZE-1:0] rd_add,
  output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic                        rsv_en,
  input  logic [ADDR_SIZE-1:0]        rsv_add,
  output logic [(1<<ADDR_SIZE)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     busy_nxt;
  logic                 wr_hit0;
  logic                 wr_hit1;
  logic                 wr0_shadowed;

  // A write "hits" only when enabled and not aimed at x0.
  assign wr_hit0      = wr_en0 && (wr_add0 != '0);
  assign wr_hit1      = wr_en1 && (wr_add1 != '0);
  assign wr0_shadowed = wr_hit1 && (wr_add1 == wr_add0);

  // Release on writeback first, then reserve, so a same-cycle reservation
  // (a newer producer) wins over the release of the older one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit0) busy_nxt[wr_add0] = 1'b0;
    if (wr_hit1) busy_nxt[wr_add1] = 1'b0;
    if (rsv_en)  busy_nxt[rsv_add] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because reads must return 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_hit1) mem[wr_add1] <= wr_data1;
      if (wr_hit0 && !wr0_shadowed) mem[wr_add0] <= wr_data0;
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    logic                 bsy;
    logic                 byp0;
    logic                 byp1;
    logic                 rsv_hit;

    assign addr = rd_add[k*ADDR_SIZE +: ADDR_SIZE];

    always_comb begin
      byp1    = (BYPASS != 0) && !rst && wr_hit1 && (wr_add1 == addr);
      byp0    = (BYPASS != 0) && !rst && wr_hit0 && (wr_add0 == addr);
      rsv_hit = rsv_en && (rsv_add == addr);
      data    = mem[addr];
      bsy     = busy[addr];
      if (addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end else begin
        if (byp1)      data = wr_data1;
        else if (byp0) data = wr_data0;
        // A forwarded result is no longer a hazard unless re-reserved this cycle.
        if ((byp1 || byp0) && !rsv_hit) bsy = 1'b0;
      end
    end

    assign rd_data[k*WORD_SIZE +: WORD_SIZE] = data;
    assign rd_busy[k]                        = bsy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypass and a non-bypass instance share stimulus and
// are compared against an array-based reference model of the register file.
module tb_reg_file_mp;

  localparam int A  = 5;
  localparam int W  = 64;
  localparam int NR = 3;
  localparam int D  = 1 << A;

  logic            clk;
  logic            rst;
  logic            wr_en0, wr_en1, rsv_en;
  logic [A-1:0]    wr_add0, wr_add1, rsv_add;
  logic [W-1:0]    wr_data0, wr_data1;
  logic [NR*A-1:0] rd_add;
  logic [NR*W-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]   rd_busy_b, rd_busy_n;
  logic [D-1:0]    busy_vec_b, busy_vec_n;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_mem  [D];
  bit           m_busy [D];

  reg_file_mp #(.ADDR_SIZE(A), .WORD_SIZE(W), .NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .wr_en0(wr_en0), .wr_add0(wr_add0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_add1(wr_add1), .wr_data1(wr_data1),
    .rd_add(rd_add), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .rsv_en(rsv_en), .rsv_add(rsv_add), .busy_vec(busy_vec_b)
  );

  reg_file_mp #(.ADDR_SIZE(A), .WORD_SIZE(W), .NUM_RD(NR), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst),
    .wr_en0(wr_en0), .wr_add0(wr_add0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_add1(wr_add1), .wr_data1(wr_data1),
    .rd_add(rd_add), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .rsv_en(rsv_en), .rsv_add(rsv_add), .busy_vec(busy_vec_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [A-1:0] rda(input int k);
    return rd_add[k*A +: A];
  endfunction

  // Reference read: x0 is zero, otherwise newest same-cycle write (port 1 first)
  // when bypassing and not in reset, otherwise the stored value.
  function automatic logic [W-1:0] exp_data(input bit byp, input logic [A-1:0] a);
    if (a == 0) return '0;
    if (byp && !rst && wr_en1 && wr_add1 == a) return wr_data1;
    if (byp && !rst && wr_en0 && wr_add0 == a) return wr_data0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [A-1:0] a);
    bit fwd;
    if (a == 0) return 1'b0;
    fwd = byp && !rst && ((wr_en1 && wr_add1 == a) || (wr_en0 && wr_add0 == a));
    if (fwd && !(rsv_en && rsv_add == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [D-1:0] exp_vec();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en0 && wr_add0 != 0) begin m_mem[wr_add0] = wr_data0; m_busy[wr_add0] = 1'b0; end
      if (wr_en1 && wr_add1 != 0) begin m_mem[wr_add1] = wr_data1; m_busy[wr_add1] = 1'b0; end
      if (rsv_en && rsv_add != 0) m_busy[rsv_add] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      check($sformatf("byp data rd%0d a%0d", k, rda(k)), rd_data_b[k*W +: W], exp_data(1, rda(k)));
      check($sformatf("nob data rd%0d a%0d", k, rda(k)), rd_data_n[k*W +: W], exp_data(0, rda(k)));
      check($sformatf("byp busy rd%0d a%0d", k, rda(k)), W'(rd_busy_b[k]), W'(exp_busy(1, rda(k))));
      check($sformatf("nob busy rd%0d a%0d", k, rda(k)), W'(rd_busy_n[k]), W'(exp_busy(0, rda(k))));
    end
    check("byp busy_vec", W'(busy_vec_b), W'(exp_vec()));
    check("nob busy_vec", W'(busy_vec_n), W'(exp_vec()));
  endtask

  // Inputs are driven at the falling edge; outputs checked 1 time unit later.
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wr_en0 = 0; wr_en1 = 0; rsv_en = 0;
    wr_add0 = '0; wr_add1 = '0; rsv_add = '0;
    wr_data0 = '0; wr_data1 = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_add = {A'(a2), A'(a1), A'(a0)};
  endtask

  function automatic logic [A-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, D - 1));
    return A'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    set_rd(0, 0, 0);
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    @(negedge clk);

    rst = 1; step(0);
    idle(); step(1);

    wr_en0 = 1; wr_add0 = 1; wr_data0 = 464; step(1);
    idle(); set_rd(1, 2, 2); #1;
    check("basic rd1", rd_data_b[W-1:0], 464);
    check("basic rd2", rd_data_b[W +: W], 0);
    step(1);

    wr_en0 = 1; wr_add0 = 17; wr_data0 = 433;
    wr_en1 = 1; wr_add1 = 17; wr_data1 = 900; step(1);
    wr_en0 = 1; wr_add0 = 3;  wr_data0 = 11;
    wr_en1 = 1; wr_add1 = 4;  wr_data1 = 22;  set_rd(17, 3, 4); step(1);
    idle(); #1;
    check("collide 17", rd_data_n[W-1:0], 900);
    check("sep 3", rd_data_n[W +: W], 11);
    check("sep 4", rd_data_n[2*W +: W], 22);
    step(1);

    wr_en0 = 1; wr_add0 = 0; wr_data0 = 'h1234; rsv_en = 1; rsv_add = 0;
    set_rd(0, 0, 0); step(1);
    idle(); #1;
    check("x0 data", rd_data_b[W-1:0], 0);
    check("x0 vec", W'(busy_vec_b[0]), 0);
    step(1);

    wr_en1 = 1; wr_add1 = 5; wr_data1 = 77; set_rd(5, 5, 5); #1;
    check("bypass new", rd_data_b[W-1:0], 77);
    check("nobypass old", rd_data_n[W-1:0], 0);
    step(1);
    idle(); #1;
    check("nobypass next", rd_data_n[W-1:0], 77);
    step(1);

    rsv_en = 1; rsv_add = 9; set_rd(9, 9, 9); step(1);
    idle(); #1;
    check("rsv vec9", W'(busy_vec_b[9]), 1);
    check("rsv rd_busy", W'(rd_busy_b[0]), 1);
    step(1);
    wr_en0 = 1; wr_add0 = 9; wr_data0 = 55; #1;
    check("wb byp busy", W'(rd_busy_b[0]), 0);
    check("wb nob busy", W'(rd_busy_n[0]), 1);
    step(1);
    idle(); #1;
    check("wb cleared", W'(busy_vec_n[9]), 0);
    step(1);
    rsv_en = 1; rsv_add = 9; wr_en1 = 1; wr_add1 = 9; wr_data1 = 66; step(1);
    idle(); #1;
    check("rsv+wr busy", W'(busy_vec_b[9]), 1);
    check("rsv+wr data", rd_data_n[W-1:0], 66);
    step(1);

    rsv_en = 1; rsv_add = 10; step(1);
    rst = 1; wr_en0 = 1; wr_add0 = 2; wr_data0 = 99; set_rd(2, 1, 17); step(1);
    idle(); #1;
    check("rst reg2", rd_data_b[W-1:0], 0);
    check("rst reg1", rd_data_b[W +: W], 0);
    check("rst reg17", rd_data_b[2*W +: W], 0);
    check("rst vec", W'(busy_vec_b), 0);
    step(1);

    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      wr_en0   = $urandom_range(0, 1);
      wr_en1   = $urandom_range(0, 1);
      rsv_en   = $urandom_range(0, 1);
      wr_add0  = pick_addr();
      wr_add1  = pick_addr();
      rsv_add  = pick_addr();
      wr_data0 = {$urandom, $urandom};
      wr_data1 = {$urandom, $urandom};
      rd_add   = {pick_addr(), pick_addr(), pick_addr()};
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
